mem_stage: RTL
==============

# mem_stage

Memory-stage consumer of the EX/MEM pipeline register outputs: it performs the data-memory access for the instruction held in M and registers the results into the MEM/WB boundary for write-back. Loads and stores take a configurable number of wait cycles, signalled upstream by a stall handshake. Non-memory instructions pass through in one cycle. It sits between the EX/MEM register and the write-back mux / register file.

## Interface
- DEPTH_WORDS, 64: data-memory depth in 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- LAT, 2: wait cycles per load/store, 0..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- regwriM  in  1  register-write enable of the M instruction.
- memtoregM  in  1  load: write-back takes memory data.
- memwriM  in  1  store: write wridataM to memory.
- aluoutM  in  32  byte address (load/store) or ALU result.
- wridataM  in  32  store data.
- wriregM  in  5  destination register.
- stallM  out  1  M instruction not finished; upstream holds all M inputs and freezes earlier stages.
- regwriW  out  1  registered write-back enable.
- memtoregW  out  1  registered load flag.
- readdataW  out  32  registered load data.
- aluoutW  out  32  registered ALU result.
- wriregW  out  5  registered destination register.
- misalignM  out  1  sticky: a misaligned load/store has been seen since reset.

## Operation
- Access instruction: memtoregM | memwriM. Word index = aluoutM[AW+1:2]; higher address bits ignored (address wraps modulo DEPTH_WORDS*4).
- Misaligned: access with aluoutM[1:0] != 0. No stall, no memory write, W gets a bubble (regwriW=0, memtoregW=0), misalignM set to 1 and held until rst.
- Wait counter cnt, 4 bits. States: IDLE (cnt=0), WAIT (0<cnt<LAT).
- stallM = aligned access AND cnt != LAT (combinational).
- Each stall cycle: cnt increments; W outputs load a bubble (regwriW=0, memtoregW=0; other W fields hold).
- Completion cycle (cnt==LAT or non-access instruction): at the edge, store writes mem[index] <= wridataM exactly once; load captures readdataW <= mem[index]; all W fields capture M fields; cnt <= 0.
- Non-access instruction: never stalls; W captures M fields; readdataW holds.
- memtoregM and memwriM both high: treated as a store (write performed), memtoregW registered as given.
- Memory contents are not reset.

## Timing
- Reset (rst high at an edge): regwriW=0, memtoregW=0, readdataW=0, aluoutW=0, wriregW=0, misalignM=0, cnt=0. stallM therefore 0 in the first cycle after reset unless an aligned access is presented with LAT>0. No memory write occurs at a reset edge.
- Aligned access presented in cycle t: stallM=1 in cycles t..t+LAT-1, stallM=0 in cycle t+LAT; W outputs valid in cycle t+LAT+1. M-stage occupancy LAT+1 cycles.
- LAT=0: no stall ever; every instruction 1 cycle M->W.
- Back-to-back store then load to the same word: load returns the stored data (store written at an earlier edge).
- Reset mid-WAIT: cnt cleared, pending store discarded, W outputs cleared.
- Inputs must remain stable while stallM=1; behaviour with changing inputs during stall is unspecified.

## Test plan
- Reset: assert rst 2 cycles with memwriM=1 -> all W outputs 0, misalignM=0, memory unchanged; stallM=0 in first cycle after release with no access.
- LAT=2, store wridataM=0xDEADBEEF to 0x10 then load 0x10 with wriregM=5 -> stallM high 2 cycles per access; readdataW=0xDEADBEEF, regwriW=1, wriregW=5 one cycle after the load's completion cycle.
- Non-access stream (3 ALU ops 0x1,0x2,0x3) -> stallM never asserts; aluoutW shows 0x1,0x2,0x3 on consecutive cycles.
- Misaligned load at 0x13 -> no stall, regwriW=0 next cycle, misalignM=1 and stays 1 through 10 following instructions.
- Address wrap (DEPTH_WORDS=64): store 0xA5A5A5A5 to 0x100, load 0x000 -> readdataW=0xA5A5A5A5.
- Reset asserted in the middle of a store's stall -> memory word unchanged afterwards, cnt restarts, next access stalls full LAT cycles.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: data-memory access for the M instruction with a fixed wait-count stall,
// then registered hand-off of the results into the MEM/WB boundary.
module mem_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriM,
  input  logic        memtoregM,
  input  logic        memwriM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] wridataM,
  input  logic [4:0]  wriregM,
  output logic        stallM,
  output logic        regwriW,
  output logic        memtoregW,
  output logic [31:0] readdataW,
  output logic [31:0] aluoutW,
  output logic [4:0]  wriregW,
  output logic        misalignM
);

  localparam int         AW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_C = 4'(LAT);

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [3:0]    r_cnt;
  logic          r_regwri;
  logic          r_memtoreg;
  logic [31:0]   r_readdata;
  logic [31:0]   r_aluout;
  logic [4:0]    r_wrireg;
  logic          r_misalign;

  logic          w_access;
  logic          w_misalign;
  logic          w_aligned;
  logic          w_stall;
  logic          w_load;
  logic          w_store_commit;
  logic [AW-1:0] w_idx;

  // NOTE: every output of this block gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    w_access       = memtoregM | memwriM;
    w_misalign     = w_access & (aluoutM[1:0] != 2'b00);
    w_aligned      = w_access & ~w_misalign;
    w_stall        = w_aligned & (r_cnt != LAT_C);
    // A load with the store flag also set is handled as a store.
    w_load         = w_aligned & memtoregM & ~memwriM;
    w_store_commit = w_aligned & memwriM & ~w_stall;
    w_idx          = aluoutM[AW+1:2];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_regwri   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_readdata <= 32'd0;
      r_aluout   <= 32'd0;
      r_wrireg   <= 5'd0;
      r_misalign <= 1'b0;
    end else if (w_stall) begin
      // Waiting on memory: push bubbles into W, keep the data fields.
      r_cnt      <= r_cnt + 4'd1;
      r_regwri   <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (w_misalign) begin
      r_cnt      <= 4'd0;
      r_regwri   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_misalign <= 1'b1;
    end else begin
      r_cnt      <= 4'd0;
      r_regwri   <= regwriM;
      r_memtoreg <= memtoregM;
      r_aluout   <= aluoutM;
      r_wrireg   <= wriregM;
      if (w_load) begin
        r_readdata <= r_mem[w_idx];
      end
    end
  end

  // NOTE: the data array is deliberately left out of reset so it maps onto RAM;
  // only the write enable is gated by rst so a reset edge never writes.
  always_ff @(posedge clk) begin
    if (!rst && w_store_commit) begin
      r_mem[w_idx] <= wridataM;
    end
  end

  assign stallM    = w_stall;
  assign regwriW   = r_regwri;
  assign memtoregW = r_memtoreg;
  assign readdataW = r_readdata;
  assign aluoutW   = r_aluout;
  assign wriregW   = r_wrireg;
  assign misalignM = r_misalign;

endmodule
